// File: rtl/uart_wb_pkg.sv
// Shared command/reply codes and state encodings for the UART-to-Wishbone bridge.
package uart_wb_pkg;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_E = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_wb_phy.sv
// 8N1 UART PHY: 2-flop RX synchroniser, RX deserialiser (1-cycle rx_valid pulse)
// and TX serialiser with tx_busy.
module uart_wb_phy
  import uart_wb_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     rx_state, rx_state_next;
  logic [1:0]    sync;
  logic          rx_s, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;

  assign rx_s = sync[1];

  always_comb begin
    rx_state_next = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_s) rx_state_next = RX_START;
      RX_START: if (rx_cnt == HALF_LAST) rx_state_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_cnt == BIT_LAST && rx_bit == 3'd7) rx_state_next = RX_STOP;
      RX_STOP:  if (rx_cnt == BIT_LAST) rx_state_next = RX_IDLE;
      default:  rx_state_next = RX_IDLE;
    endcase
  end

  // Counter restarts on every state change, so DATA samples land one full bit after the start midpoint.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync     <= '1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      sync     <= {sync[0], rx};
      rx_prev  <= rx_s;
      rx_state <= rx_state_next;
      rx_valid <= 1'b0;
      if (rx_state_next != rx_state || rx_cnt == BIT_LAST) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_START) rx_bit <= '0;
      if (rx_state == RX_DATA && rx_cnt == BIT_LAST) begin
        rx_shift <= {rx_s, rx_shift[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
      if (rx_state == RX_STOP && rx_cnt == BIT_LAST && rx_s) begin
        rx_valid <= 1'b1;
        rx_data  <= rx_shift;
      end
    end
  end

  logic [9:0]    tx_shift;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_left;

  assign tx_busy = (tx_left != 4'd0);
  assign tx      = tx_shift[0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_shift <= '1;
      tx_cnt   <= '0;
      tx_left  <= '0;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_shift <= {1'b1, tx_data, 1'b0};
        tx_left  <= 4'd10;
        tx_cnt   <= '0;
      end
    end else if (tx_cnt == BIT_LAST) begin
      tx_cnt   <= '0;
      tx_shift <= {1'b1, tx_shift[9:1]};
      tx_left  <= tx_left - 1'b1;
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_wb_bridge.sv
// UART-to-Wishbone master: 'W'/'R' host commands become single 32-bit WB cycles.
// Optional bus timeout with 'E' reply enabled by defining UART_WB_TIMEOUT_EN.
module uart_wb_bridge
  import uart_wb_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
`ifdef UART_WB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 255
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  output logic        tx,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy
);

  state_t      state, state_next;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_start, tx_busy;
  logic [1:0]  fld_cnt;
  logic [1:0]  resp_cnt;
  logic        resp_done;
  logic [31:0] rsp_shift;
  logic        timeout_hit;

  uart_wb_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx       (rx),
    .tx       (tx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (rsp_shift[31:24]),
    .tx_start (tx_start),
    .tx_busy  (tx_busy)
  );

  // The bus cycle is exactly the BUS state, so reset or ack drops it on the same edge.
  assign wbm_cyc_o = (state == S_BUS);
  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_sel_o = wbm_cyc_o ? 4'hF : 4'h0;
  assign busy      = (state != S_IDLE);

`ifdef UART_WB_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] to_cnt;

  assign timeout_hit = (to_cnt <= TW'(1));

  always_ff @(posedge clk) begin
    if (!reset_n) to_cnt <= '0;
    else if (state != S_BUS) to_cnt <= TW'(TIMEOUT);
    else to_cnt <= to_cnt - 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    tx_start   = 1'b0;
    unique case (state)
      S_IDLE: if (rx_valid && (rx_data == CMD_W || rx_data == CMD_R)) state_next = S_ADDR;
      S_ADDR: if (rx_valid && fld_cnt == 2'd3) state_next = wbm_we_o ? S_DATA : S_BUS;
      S_DATA: if (rx_valid && fld_cnt == 2'd3) state_next = S_BUS;
      S_BUS:  if (wbm_ack_i || timeout_hit) state_next = S_RESP;
      S_RESP: begin
        if (!tx_busy) begin
          if (resp_done) state_next = S_IDLE;
          else tx_start = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      fld_cnt   <= '0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_shift <= '0;
      resp_cnt  <= '0;
      resp_done <= 1'b0;
    end else begin
      state <= state_next;
      unique case (state)
        S_IDLE: begin
          fld_cnt <= '0;
          if (state_next == S_ADDR) wbm_we_o <= (rx_data == CMD_W);
        end
        S_ADDR: if (rx_valid) begin
          wbm_adr_o <= {wbm_adr_o[23:0], rx_data};
          fld_cnt   <= fld_cnt + 1'b1;
        end
        S_DATA: if (rx_valid) begin
          wbm_dat_o <= {wbm_dat_o[23:0], rx_data};
          fld_cnt   <= fld_cnt + 1'b1;
        end
        S_BUS: begin
          resp_done <= 1'b0;
          if (wbm_ack_i) begin
            rsp_shift <= wbm_we_o ? {RSP_K, 24'h0} : wbm_dat_i;
            resp_cnt  <= wbm_we_o ? 2'd0 : 2'd3;
          end else if (timeout_hit) begin
            rsp_shift <= {RSP_E, 24'h0};
            resp_cnt  <= 2'd0;
          end
        end
        S_RESP: if (tx_start) begin
          rsp_shift <= {rsp_shift[23:0], 8'h00};
          if (resp_cnt == 2'd0) resp_done <= 1'b1;
          else resp_cnt <= resp_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
